// File: rtl/memory_access.sv
// memory_access: RV32I load/store stage between execute and writeback, req/ack data-memory port.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses raise mem_o_misalign instead of issuing req.
`ifndef LOAD_WORD
`define LOAD_WORD 7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif

module memory_access #(
    parameter int unsigned AWIDTH       = 5,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned FUNCT_WIDTH  = 3,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH = 7
) (
    input  logic                    ex_clk,
    input  logic                    ex_rst,
    input  logic                    mem_i_ce,
    input  logic                    mem_i_flush,
    input  logic [OPCODE_WIDTH-1:0] mem_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  mem_i_funct3,
    input  logic [DWIDTH-1:0]       mem_i_alu_value,
    input  logic [DWIDTH-1:0]       mem_i_data_rs2,
    input  logic [AWIDTH-1:0]       mem_i_addr_rd,
    input  logic [DWIDTH-1:0]       mem_i_data_rd,
    input  logic                    mem_i_we_reg,
    input  logic                    mem_i_valid,
    input  logic [PC_WIDTH-1:0]     mem_i_pc,
    output logic                    mem_o_ce,
    output logic                    mem_o_stall,
    output logic [AWIDTH-1:0]       mem_o_addr_rd,
    output logic [DWIDTH-1:0]       mem_o_data_rd,
    output logic                    mem_o_we_reg,
    output logic [PC_WIDTH-1:0]     mem_o_pc,
    output logic                    mem_o_req,
    output logic                    mem_o_wr,
    output logic [DWIDTH-1:0]       mem_o_addr,
    output logic [DWIDTH-1:0]       mem_o_wdata,
    output logic [3:0]              mem_o_strb,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                    mem_o_misalign,
    output logic [DWIDTH-1:0]       mem_o_bad_addr,
`endif
    input  logic                    mem_i_ack,
    input  logic [DWIDTH-1:0]       mem_i_rdata
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic                   ce_q, ce_d, we_reg_q, we_reg_d, req_q, req_d, wr_q, wr_d;
    logic [AWIDTH-1:0]      addr_rd_q, addr_rd_d;
    logic [DWIDTH-1:0]      data_rd_q, data_rd_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [3:0]             strb_q, strb_d;
    logic [FUNCT_WIDTH-1:0] funct3_q, funct3_d;
    logic [1:0]             off_q, off_d;
    logic                   misaligned;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                   misalign_q, misalign_d;
    logic [DWIDTH-1:0]      bad_addr_q, bad_addr_d;
`endif

    logic              accept, is_load, is_store, is_byte, is_half;
    logic [1:0]        off_in;
    logic [3:0]        st_strb;
    logic [DWIDTH-1:0] st_wdata, ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // Decode of the instruction presented by execute.
    always_comb begin
        accept   = mem_i_ce & ~mem_i_flush & (state_q == StIdle);
        is_load  = (mem_i_opcode == `LOAD_WORD);
        is_store = (mem_i_opcode == `STORE_WORD);
        is_byte  = (mem_i_funct3[1:0] == 2'b00);
        is_half  = (mem_i_funct3[1:0] == 2'b01);
        off_in   = mem_i_alu_value[1:0];
        st_strb  = 4'b1111;
        st_wdata = mem_i_data_rs2;
        if (is_byte) begin
            st_strb  = 4'b0001 << off_in;
            st_wdata = {4{mem_i_data_rs2[7:0]}};
        end else if (is_half) begin
            st_strb  = off_in[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{mem_i_data_rs2[15:0]}};
        end
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = (is_load | is_store) & (is_half ? off_in[0] : (~is_byte & (off_in != 2'b00)));
`else
        misaligned = 1'b0;
`endif
    end

    // Load data extraction uses the size/offset captured at accept.
    always_comb begin
        ld_byte = mem_i_rdata[{off_q, 3'b000} +: 8];
        ld_half = mem_i_rdata[{off_q[1], 4'b0000} +: 16];
        if (funct3_q[1:0] == 2'b00) begin
            ld_data = {{(DWIDTH-8){ld_byte[7] & ~funct3_q[2]}}, ld_byte};
        end else if (funct3_q[1:0] == 2'b01) begin
            ld_data = {{(DWIDTH-16){ld_half[15] & ~funct3_q[2]}}, ld_half};
        end else begin
            ld_data = mem_i_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        ce_d      = 1'b0;
        we_reg_d  = 1'b0;
        req_d     = req_q;
        wr_d      = wr_q;
        addr_rd_d = addr_rd_q;
        data_rd_d = data_rd_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        funct3_d  = funct3_q;
        off_d     = off_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_rd_d = mem_i_addr_rd;
                    pc_d      = mem_i_pc;
                    if ((is_load | is_store) & misaligned) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
                        bad_addr_d = mem_i_alu_value;
`endif
                    end else if (is_load | is_store) begin
                        state_d  = StBusy;
                        req_d    = 1'b1;
                        wr_d     = is_store;
                        addr_d   = {mem_i_alu_value[DWIDTH-1:2], 2'b00};
                        wdata_d  = st_wdata;
                        strb_d   = is_store ? st_strb : 4'b0000;
                        funct3_d = mem_i_funct3;
                        off_d    = off_in;
                    end else begin
                        ce_d      = 1'b1;
                        data_rd_d = mem_i_data_rd;
                        we_reg_d  = (mem_i_we_reg | mem_i_valid) & (mem_i_addr_rd != '0);
                    end
                end
            end
            StBusy: begin
                if (mem_i_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    ce_d    = 1'b1;
                    if (!wr_q) begin
                        data_rd_d = ld_data;
                        we_reg_d  = (addr_rd_q != '0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ex_clk or negedge ex_rst) begin
        if (!ex_rst) begin
            state_q   <= StIdle;
            ce_q      <= 1'b0;
            we_reg_q  <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_rd_q <= '0;
            data_rd_q <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ce_q      <= ce_d;
            we_reg_q  <= we_reg_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            addr_rd_q <= addr_rd_d;
            data_rd_q <= data_rd_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            funct3_q  <= funct3_d;
            off_q     <= off_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
`endif
        end
    end

    assign mem_o_ce      = ce_q;
    assign mem_o_stall   = (state_q == StBusy);
    assign mem_o_addr_rd = addr_rd_q;
    assign mem_o_data_rd = data_rd_q;
    assign mem_o_we_reg  = we_reg_q;
    assign mem_o_pc      = pc_q;
    assign mem_o_req     = req_q;
    assign mem_o_wr      = wr_q;
    assign mem_o_addr    = addr_q;
    assign mem_o_wdata   = wdata_q;
    assign mem_o_strb    = strb_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign mem_o_misalign = misalign_q;
    assign mem_o_bad_addr = bad_addr_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: randomized loads/stores/ALU ops against a byte-level reference model.
// Trap scenarios are compiled in when MEM_MISALIGN_TRAP_EN is defined.
`timescale 1ns/1ps
module tb_memory_access;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpAlu   = 7'b0110011;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic        ex_clk = 1'b0;
    logic        ex_rst;
    logic        mem_i_ce, mem_i_flush, mem_i_we_reg, mem_i_valid, mem_i_ack;
    logic [6:0]  mem_i_opcode;
    logic [2:0]  mem_i_funct3;
    logic [31:0] mem_i_alu_value, mem_i_data_rs2, mem_i_data_rd, mem_i_pc, mem_i_rdata;
    logic [4:0]  mem_i_addr_rd;
    logic        mem_o_ce, mem_o_stall, mem_o_we_reg, mem_o_req, mem_o_wr;
    logic [4:0]  mem_o_addr_rd;
    logic [31:0] mem_o_data_rd, mem_o_pc, mem_o_addr, mem_o_wdata;
    logic [3:0]  mem_o_strb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_o_misalign;
    logic [31:0] mem_o_bad_addr;
`endif

    int vectors = 0;
    int miscompares = 0;

    memory_access dut (
        .ex_clk(ex_clk), .ex_rst(ex_rst), .mem_i_ce(mem_i_ce), .mem_i_flush(mem_i_flush),
        .mem_i_opcode(mem_i_opcode), .mem_i_funct3(mem_i_funct3),
        .mem_i_alu_value(mem_i_alu_value), .mem_i_data_rs2(mem_i_data_rs2),
        .mem_i_addr_rd(mem_i_addr_rd), .mem_i_data_rd(mem_i_data_rd),
        .mem_i_we_reg(mem_i_we_reg), .mem_i_valid(mem_i_valid), .mem_i_pc(mem_i_pc),
        .mem_o_ce(mem_o_ce), .mem_o_stall(mem_o_stall), .mem_o_addr_rd(mem_o_addr_rd),
        .mem_o_data_rd(mem_o_data_rd), .mem_o_we_reg(mem_o_we_reg), .mem_o_pc(mem_o_pc),
        .mem_o_req(mem_o_req), .mem_o_wr(mem_o_wr), .mem_o_addr(mem_o_addr),
        .mem_o_wdata(mem_o_wdata), .mem_o_strb(mem_o_strb),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_o_misalign(mem_o_misalign), .mem_o_bad_addr(mem_o_bad_addr),
`endif
        .mem_i_ack(mem_i_ack), .mem_i_rdata(mem_i_rdata)
    );

    always #5 ex_clk = ~ex_clk;

    // Reference model: access size in bytes, lane base, and byte-wise lane mapping.
    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1]) return 4;
        if (f3[0]) return 2;
        return 1;
    endfunction

    function automatic int unsigned lane_base(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size = acc_size(f3);
        return (int'(addr[1:0]) / size) * size;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned size = acc_size(f3);
        longint val = (longint'(rdata) >> (8 * lane_base(f3, addr))) & ((64'd1 << (8 * size)) - 1);
        if (size < 4 && !f3[2] && val >= (64'd1 << (8 * size - 1))) val -= (64'd1 << (8 * size));
        return val[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s = '0;
        for (int b = 0; b < 4; b++)
            if (b >= lane_base(f3, addr) && b < lane_base(f3, addr) + acc_size(f3)) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = rs2[8*(b % acc_size(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] rand_addr(input logic [2:0] f3);
        logic [31:0] a = $urandom;
        if (TrapEn) a = a & ~(32'(acc_size(f3)) - 32'd1);
        return a;
    endfunction

    task automatic drive_idle();
        mem_i_ce = 0; mem_i_flush = 0; mem_i_ack = 0; mem_i_opcode = OpAlu; mem_i_funct3 = 0;
        mem_i_alu_value = 0; mem_i_data_rs2 = 0; mem_i_addr_rd = 0; mem_i_data_rd = 0;
        mem_i_we_reg = 0; mem_i_valid = 0; mem_i_pc = 0; mem_i_rdata = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        ex_rst = 0;
        #12;
        vectors++;
        if ({mem_o_ce, mem_o_stall, mem_o_we_reg, mem_o_req, mem_o_wr, mem_o_strb} !== 9'b0 ||
            mem_o_addr_rd !== 0 || mem_o_data_rd !== 0 || mem_o_pc !== 0 || mem_o_addr !== 0 ||
            mem_o_wdata !== 0) begin
            miscompares++;
            $display("FAIL reset_outputs: ce=%b stall=%b we=%b req=%b strb=%h data=%h, required all 0",
                     mem_o_ce, mem_o_stall, mem_o_we_reg, mem_o_req, mem_o_strb, mem_o_data_rd);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++;
        if (mem_o_misalign !== 0 || mem_o_bad_addr !== 0) begin
            miscompares++;
            $display("FAIL reset_trap: misalign=%b bad_addr=%h, required 0", mem_o_misalign, mem_o_bad_addr);
        end
`endif
        @(negedge ex_clk);
        ex_rst = 1;
    endtask

    task automatic test_alu();
        logic [4:0]  rd;
        logic [31:0] res, pc;
        logic        we, vld, exp_we;
        for (int i = 0; i < 16; i++) begin
            rd  = (i == 0) ? 5'd3 : (i == 1) ? 5'd0 : 5'($urandom);
            res = (i < 2) ? 32'd5 : $urandom;
            pc  = $urandom;
            we  = (i < 2) ? 1'b0 : 1'($urandom);
            vld = (i < 2) ? 1'b1 : 1'($urandom);
            exp_we = (we | vld) && rd != 0;
            @(negedge ex_clk);
            mem_i_ce = 1; mem_i_opcode = OpAlu; mem_i_addr_rd = rd; mem_i_data_rd = res;
            mem_i_pc = pc; mem_i_we_reg = we; mem_i_valid = vld; mem_i_funct3 = 3'($urandom);
            mem_i_alu_value = $urandom;
            @(negedge ex_clk);
            mem_i_ce = 0;
            vectors++;
            if (mem_o_ce !== 1 || mem_o_we_reg !== exp_we || mem_o_data_rd !== res ||
                mem_o_addr_rd !== rd || mem_o_pc !== pc || mem_o_req !== 0 || mem_o_stall !== 0) begin
                miscompares++;
                $display("FAIL alu_%0d: ce=%b we=%b data=%h rd=%0d pc=%h req=%b, required ce=1 we=%b data=%h rd=%0d pc=%h req=0",
                         i, mem_o_ce, mem_o_we_reg, mem_o_data_rd, mem_o_addr_rd, mem_o_pc, mem_o_req,
                         exp_we, res, rd, pc);
            end
        end
        @(negedge ex_clk);
        vectors++;
        if (mem_o_ce !== 0 || mem_o_we_reg !== 0) begin
            miscompares++;
            $display("FAIL alu_idle: ce=%b we=%b, required 0 0", mem_o_ce, mem_o_we_reg);
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3;
        logic [31:0] addr, rdata, pc, exp;
        logic [4:0]  rd;
        int          lat;
        for (int i = 0; i < 20; i++) begin
            case (i)
                0: begin f3 = 3'b010; addr = 32'h10; rdata = 32'hDEADBEEF; lat = 2; end
                1: begin f3 = 3'b000; addr = 32'h13; rdata = 32'h80FFFF7F; lat = 1; end
                2: begin f3 = 3'b100; addr = 32'h13; rdata = 32'h80FFFF7F; lat = 3; end
                3: begin f3 = 3'b001; addr = 32'h12; rdata = 32'h80FFFF7F; lat = 1; end
                default: begin
                    f3 = 3'($urandom); addr = rand_addr(f3); rdata = $urandom;
                    lat = $urandom_range(1, 3);
                end
            endcase
            rd = (i < 4) ? 5'd10 : 5'($urandom);
            pc = $urandom;
            exp = ref_load(f3, addr, rdata);
            @(negedge ex_clk);
            mem_i_ce = 1; mem_i_opcode = OpLoad; mem_i_funct3 = f3; mem_i_alu_value = addr;
            mem_i_addr_rd = rd; mem_i_pc = pc; mem_i_data_rs2 = $urandom; mem_i_we_reg = 0;
            for (int c = 0; c < lat; c++) begin
                @(negedge ex_clk);
                mem_i_ce = 0;
                vectors++;
                if ({mem_o_req, mem_o_wr, mem_o_stall, mem_o_ce, mem_o_strb} !== 8'b1010_0000 ||
                    mem_o_addr !== {addr[31:2], 2'b00}) begin
                    miscompares++;
                    $display("FAIL load_req_%0d_%0d: req=%b wr=%b stall=%b ce=%b strb=%b addr=%h, required 1 0 1 0 0000 %h",
                             i, c, mem_o_req, mem_o_wr, mem_o_stall, mem_o_ce, mem_o_strb, mem_o_addr,
                             {addr[31:2], 2'b00});
                end
            end
            mem_i_ack = 1; mem_i_rdata = rdata;
            @(negedge ex_clk);
            mem_i_ack = 0; mem_i_rdata = $urandom;
            vectors++;
            if (mem_o_ce !== 1 || mem_o_req !== 0 || mem_o_stall !== 0 || mem_o_data_rd !== exp ||
                mem_o_we_reg !== (rd != 0) || mem_o_addr_rd !== rd || mem_o_pc !== pc) begin
                miscompares++;
                $display("FAIL load_done_%0d: f3=%b addr=%h ce=%b req=%b data=%h we=%b rd=%0d, required ce=1 req=0 data=%h we=%b rd=%0d",
                         i, f3, addr, mem_o_ce, mem_o_req, mem_o_data_rd, mem_o_we_reg, mem_o_addr_rd,
                         exp, (rd != 0), rd);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3;
        logic [31:0] addr, rs2;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                f3 = 3'b001; addr = 32'h22; rs2 = 32'h1234ABCD; lat = 1;
            end else begin
                f3 = {1'b0, 2'($urandom)}; addr = rand_addr(f3); rs2 = $urandom;
                lat = $urandom_range(1, 3);
            end
            @(negedge ex_clk);
            mem_i_ce = 1; mem_i_opcode = OpStore; mem_i_funct3 = f3; mem_i_alu_value = addr;
            mem_i_data_rs2 = rs2; mem_i_addr_rd = 5'($urandom); mem_i_we_reg = 1; mem_i_valid = 1;
            for (int c = 0; c < lat; c++) begin
                @(negedge ex_clk);
                mem_i_ce = 0;
                vectors++;
                if ({mem_o_req, mem_o_wr, mem_o_stall} !== 3'b111 || mem_o_addr !== {addr[31:2], 2'b00} ||
                    mem_o_strb !== ref_strb(f3, addr) || mem_o_wdata !== ref_wdata(f3, rs2)) begin
                    miscompares++;
                    $display("FAIL store_req_%0d_%0d: req=%b wr=%b addr=%h strb=%b wdata=%h, required 1 1 %h %b %h",
                             i, c, mem_o_req, mem_o_wr, mem_o_addr, mem_o_strb, mem_o_wdata,
                             {addr[31:2], 2'b00}, ref_strb(f3, addr), ref_wdata(f3, rs2));
                end
            end
            mem_i_ack = 1;
            @(negedge ex_clk);
            mem_i_ack = 0;
            vectors++;
            if (mem_o_ce !== 1 || mem_o_we_reg !== 0 || mem_o_req !== 0 || mem_o_stall !== 0) begin
                miscompares++;
                $display("FAIL store_done_%0d: ce=%b we=%b req=%b stall=%b, required 1 0 0 0",
                         i, mem_o_ce, mem_o_we_reg, mem_o_req, mem_o_stall);
            end
        end
    endtask

    // A younger ALU op waits in execute (with a flush pulse) while the load is outstanding.
    task automatic test_back_to_back();
        logic [31:0] rdata = $urandom;
        @(negedge ex_clk);
        mem_i_ce = 1; mem_i_opcode = OpLoad; mem_i_funct3 = 3'b010; mem_i_alu_value = 32'h40;
        mem_i_addr_rd = 5'd7; mem_i_pc = 32'h100;
        @(negedge ex_clk);
        mem_i_opcode = OpAlu; mem_i_addr_rd = 5'd9; mem_i_data_rd = 32'h55; mem_i_valid = 1;
        mem_i_pc = 32'h104; mem_i_flush = 1; mem_i_ack = 1; mem_i_rdata = rdata;
        vectors++;
        if (mem_o_ce !== 0 || mem_o_stall !== 1 || mem_o_req !== 1) begin
            miscompares++;
            $display("FAIL b2b_busy: ce=%b stall=%b req=%b, required 0 1 1", mem_o_ce, mem_o_stall, mem_o_req);
        end
        @(negedge ex_clk);
        mem_i_flush = 0; mem_i_ack = 0;
        vectors++;
        if (mem_o_ce !== 1 || mem_o_data_rd !== rdata || mem_o_addr_rd !== 7 || mem_o_we_reg !== 1 ||
            mem_o_stall !== 0 || mem_o_pc !== 32'h100) begin
            miscompares++;
            $display("FAIL b2b_load: ce=%b data=%h rd=%0d we=%b stall=%b, required 1 %h 7 1 0",
                     mem_o_ce, mem_o_data_rd, mem_o_addr_rd, mem_o_we_reg, mem_o_stall, rdata);
        end
        @(negedge ex_clk);
        mem_i_ce = 0;
        vectors++;
        if (mem_o_ce !== 1 || mem_o_data_rd !== 32'h55 || mem_o_addr_rd !== 9 || mem_o_we_reg !== 1 ||
            mem_o_pc !== 32'h104) begin
            miscompares++;
            $display("FAIL b2b_alu: ce=%b data=%h rd=%0d we=%b pc=%h, required 1 00000055 9 1 00000104",
                     mem_o_ce, mem_o_data_rd, mem_o_addr_rd, mem_o_we_reg, mem_o_pc);
        end
        @(negedge ex_clk);
        vectors++;
        if (mem_o_ce !== 0 || mem_o_we_reg !== 0) begin
            miscompares++;
            $display("FAIL b2b_idle: ce=%b we=%b, required 0 0", mem_o_ce, mem_o_we_reg);
        end
    endtask

    task automatic test_flush_and_idle_ack();
        @(negedge ex_clk);
        mem_i_ce = 1; mem_i_flush = 1; mem_i_opcode = OpLoad; mem_i_funct3 = 3'b010;
        mem_i_alu_value = 32'h80; mem_i_addr_rd = 5'd4;
        @(negedge ex_clk);
        mem_i_ce = 0; mem_i_flush = 0; mem_i_ack = 1; mem_i_rdata = $urandom;
        vectors++;
        if (mem_o_req !== 0 || mem_o_ce !== 0 || mem_o_stall !== 0) begin
            miscompares++;
            $display("FAIL flush_load: req=%b ce=%b stall=%b, required 0 0 0", mem_o_req, mem_o_ce, mem_o_stall);
        end
        @(negedge ex_clk);
        mem_i_ack = 0;
        vectors++;
        if (mem_o_req !== 0 || mem_o_ce !== 0 || mem_o_stall !== 0 || mem_o_we_reg !== 0) begin
            miscompares++;
            $display("FAIL idle_ack: req=%b ce=%b stall=%b we=%b, required 0 0 0 0",
                     mem_o_req, mem_o_ce, mem_o_stall, mem_o_we_reg);
        end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        @(negedge ex_clk);
        mem_i_ce = 1; mem_i_opcode = OpLoad; mem_i_funct3 = 3'b010; mem_i_alu_value = 32'h11;
        mem_i_addr_rd = 5'd5;
        @(negedge ex_clk);
        mem_i_funct3 = 3'b000;
        vectors++;
        if (mem_o_misalign !== 1 || mem_o_bad_addr !== 32'h11 || mem_o_req !== 0 || mem_o_ce !== 0 ||
            mem_o_we_reg !== 0 || mem_o_stall !== 0) begin
            miscompares++;
            $display("FAIL misalign_lw: mis=%b bad=%h req=%b ce=%b stall=%b, required 1 00000011 0 0 0",
                     mem_o_misalign, mem_o_bad_addr, mem_o_req, mem_o_ce, mem_o_stall);
        end
        @(negedge ex_clk);
        mem_i_ce = 0;
        vectors++;
        if (mem_o_misalign !== 0 || mem_o_bad_addr !== 32'h11 || mem_o_req !== 1 ||
            mem_o_strb !== 4'b0000 || mem_o_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL misalign_lb: mis=%b bad=%h req=%b addr=%h, required 0 00000011 1 00000010",
                     mem_o_misalign, mem_o_bad_addr, mem_o_req, mem_o_addr);
        end
        mem_i_ack = 1; mem_i_rdata = 32'h0000_9C00;
        @(negedge ex_clk);
        mem_i_ack = 0;
        vectors++;
        if (mem_o_ce !== 1 || mem_o_data_rd !== 32'hFFFF_FF9C) begin
            miscompares++;
            $display("FAIL misalign_lb_done: ce=%b data=%h, required 1 ffffff9c", mem_o_ce, mem_o_data_rd);
        end
    endtask
`endif

    task automatic test_reset_mid_busy();
        @(negedge ex_clk);
        mem_i_ce = 1; mem_i_opcode = OpStore; mem_i_funct3 = 3'b010; mem_i_alu_value = 32'h30;
        @(negedge ex_clk);
        mem_i_ce = 0;
        vectors++;
        if (mem_o_req !== 1 || mem_o_stall !== 1) begin
            miscompares++;
            $display("FAIL busy_before_rst: req=%b stall=%b, required 1 1", mem_o_req, mem_o_stall);
        end
        #2 ex_rst = 0;
        #1;
        vectors++;
        if (mem_o_req !== 0 || mem_o_stall !== 0 || mem_o_strb !== 0 || mem_o_wr !== 0) begin
            miscompares++;
            $display("FAIL async_rst: req=%b stall=%b strb=%b wr=%b, required 0 0 0000 0",
                     mem_o_req, mem_o_stall, mem_o_strb, mem_o_wr);
        end
        @(negedge ex_clk);
        ex_rst = 1; mem_i_ack = 1;
        @(negedge ex_clk);
        mem_i_ack = 0;
        vectors++;
        if (mem_o_req !== 0 || mem_o_stall !== 0 || mem_o_ce !== 0) begin
            miscompares++;
            $display("FAIL after_rst: req=%b stall=%b ce=%b, required 0 0 0", mem_o_req, mem_o_stall, mem_o_ce);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_flush_and_idle_ack();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, required completion");
        $fatal(1);
    end
endmodule
